// File: rtl/cnn_pkg.sv
// Shared constants and types for the cnn_core pooling/unpooling stages.
// Window size, value-mapping modes and the expand FSM state encoding.
package cnn_pkg;

    localparam int CNN_DATA_W     = 32;
    localparam int FM_W           = 3;
    localparam int FM_H           = 3;
    localparam int WIN            = 2;
    localparam int MODE_REPLICATE = 0;
    localparam int MODE_AVG_GRAD  = 1;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

endpackage

// File: rtl/avg_unpool_unit.sv
// Per-element value mapping for unpooling: replicate or avg-pool gradient.
// Counterpart of avg_pool_unit; further unpool modes slot in here.
module avg_unpool_unit
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int MODE   = MODE_REPLICATE
) (
    input  logic signed [DATA_W-1:0] in_val,
    output logic signed [DATA_W-1:0] out_val
);

    // Map one input element to the value spread over its 2x2 window
    always_comb begin
        out_val = in_val;
        if (MODE == MODE_AVG_GRAD) begin
            out_val = in_val >>> 2;
        end
    end

endmodule

// File: rtl/unpool_layer.sv
// 2x expansion of a feature map, one 2x2 output block per clock.
// Input is snapshotted on start so it may change while expanding.
module unpool_layer
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int IN_W   = FM_W,
    parameter int IN_H   = FM_H,
    parameter int MODE   = MODE_REPLICATE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] input_fm  [0:IN_W*IN_H-1],
    output logic                     done,
    output logic signed [DATA_W-1:0] output_fm [0:4*IN_W*IN_H-1]
);

    localparam int N     = IN_W * IN_H;
    localparam int OW    = WIN * IN_W;
    localparam int ON    = 4 * N;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int ROW_W = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int COL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int OA_W  = $clog2(ON);

    state_t state;
    state_t next_state;

    logic signed [DATA_W-1:0] in_buf [0:N-1];
    logic        [IDX_W-1:0]  idx;
    logic        [ROW_W-1:0]  row;
    logic        [COL_W-1:0]  col;
    logic        [OA_W-1:0]   base;
    logic        [OA_W-1:0]   base_lo;
    logic signed [DATA_W-1:0] v;

    logic load;
    logic write_en;
    logic last;

    assign last = (idx == IDX_W'(N - 1));

    avg_unpool_unit #(
        .DATA_W (DATA_W),
        .MODE   (MODE)
    ) u_unit (
        .in_val  (in_buf[idx]),
        .out_val (v)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control strobes
    always_comb begin
        next_state = state;
        load       = 1'b0;
        write_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = EXPAND;
                end
            end
            EXPAND: begin
                write_en = 1'b1;
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = EXPAND;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Top-left output address of the current block and the row below it
    always_comb begin
        base    = OA_W'(2 * int'(row) * OW + 2 * int'(col));
        base_lo = base + OA_W'(OW);
    end

    // Snapshot, block counters, done flag and output block writes
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
            idx  <= '0;
            row  <= '0;
            col  <= '0;
            for (int i = 0; i < N; i++) begin
                in_buf[i] <= '0;
            end
            for (int i = 0; i < ON; i++) begin
                output_fm[i] <= '0;
            end
        end else if (load) begin
            done <= 1'b0;
            idx  <= '0;
            row  <= '0;
            col  <= '0;
            for (int i = 0; i < N; i++) begin
                in_buf[i] <= input_fm[i];
            end
        end else if (write_en) begin
            output_fm[base]              <= v;
            output_fm[base + OA_W'(1)]   <= v;
            output_fm[base_lo]           <= v;
            output_fm[base_lo + OA_W'(1)] <= v;
            if (last) begin
                done <= 1'b1;
            end else begin
                idx <= idx + IDX_W'(1);
                if (col == COL_W'(IN_W - 1)) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_unpool_layer.sv
// Randomized self-checking bench for unpool_layer, both value modes.
// A block-level model tracks the expected map edge by edge.
module tb_unpool_layer;

    localparam int N  = 9;
    localparam int IW = 3;
    localparam int OW = 6;
    localparam int ON = 36;

    logic clk;
    logic rst;
    logic start;
    logic signed [31:0] in_fm [0:N-1];
    logic               done0;
    logic               done1;
    logic signed [31:0] out0 [0:ON-1];
    logic signed [31:0] out1 [0:ON-1];

    logic signed [31:0] nxt  [0:N-1];
    logic signed [31:0] snap [0:N-1];
    logic signed [31:0] m0   [0:ON-1];
    logic signed [31:0] m1   [0:ON-1];

    int checks;
    int errors;

    unpool_layer #(.DATA_W(32), .IN_W(3), .IN_H(3), .MODE(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .input_fm  (in_fm),
        .done      (done0),
        .output_fm (out0)
    );

    unpool_layer #(.DATA_W(32), .IN_W(3), .IN_H(3), .MODE(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .input_fm  (in_fm),
        .done      (done1),
        .output_fm (out1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [31:0] quarter(input logic signed [31:0] a);
        longint x;
        longint q;
        x = a;
        q = x / 4;
        if (x < 0 && (x % 4) != 0) q = q - 1;
        return q[31:0];
    endfunction

    function automatic void put_block(input int k);
        int r;
        int c;
        int o;
        r = k / IW;
        c = k % IW;
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                o = (2 * r + dr) * OW + 2 * c + dc;
                m0[o] = snap[k];
                m1[o] = quarter(snap[k]);
            end
        end
    endfunction

    function automatic void clear_model();
        for (int o = 0; o < ON; o++) begin
            m0[o] = '0;
            m1[o] = '0;
        end
    endfunction

    task automatic check_all(input string tag, input logic exp_done);
        check($sformatf("%s done0", tag), {31'b0, done0}, {31'b0, exp_done});
        check($sformatf("%s done1", tag), {31'b0, done1}, {31'b0, exp_done});
        for (int o = 0; o < ON; o++) begin
            check($sformatf("%s rep[%0d]", tag, o), out0[o], m0[o]);
            check($sformatf("%s avg[%0d]", tag, o), out1[o], m1[o]);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) nxt[k] = $urandom;
    endtask

    task automatic run(input string tag, input bit disturb, input int abort_at);
        for (int k = 0; k < N; k++) begin
            in_fm[k] = nxt[k];
            snap[k]  = nxt[k];
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check_all($sformatf("%s e0", tag), 1'b0);
        for (int e = 1; e <= N; e++) begin
            if (disturb && e >= 3 && e <= 6) begin
                start = 1'($urandom_range(0, 1));
                for (int k = 0; k < N; k++) in_fm[k] = $urandom;
            end else begin
                start = 1'b0;
            end
            if (e == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                start = 1'b0;
                clear_model();
                check_all($sformatf("%s rst", tag), 1'b0);
                for (int i = 0; i < 2; i++) begin
                    tick();
                    check_all($sformatf("%s idle%0d", tag, i), 1'b0);
                end
                return;
            end
            tick();
            put_block(e - 1);
            check_all($sformatf("%s e%0d", tag, e), e == N);
        end
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_all($sformatf("%s hold%0d", tag, i), 1'b1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        for (int k = 0; k < N; k++) in_fm[k] = '0;
        clear_model();
        tick();
        tick();
        check_all("reset", 1'b0);
        rst = 1'b0;
        tick();
        check_all("idle", 1'b0);

        for (int k = 0; k < N; k++) nxt[k] = 32'(4 * k);
        run("ramp", 1'b0, 0);

        fill_random();
        nxt[0] = -32'sd5;
        nxt[8] = 32'sd7;
        run("floor", 1'b0, 0);

        fill_random();
        nxt[0] = 32'h8000_0000;
        nxt[8] = 32'h7FFF_FFFF;
        run("extreme", 1'b0, 0);

        fill_random();
        run("disturb", 1'b1, 0);

        fill_random();
        run("abort", 1'b0, 5);

        fill_random();
        run("after_rst", 1'b0, 0);

        for (int t = 0; t < 3; t++) begin
            fill_random();
            run($sformatf("restart%0d", t), 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
